enable_gen: RTL and testbench
=============================

Name: enable_gen

Overview:
- Programmable strobe generator that sits directly upstream of the counter block and drives its enable input.
- Emits one-cycle enable pulses every (div+1) clocks, in one of two modes:
  - continuous: pulses run until stopped;
  - burst: exactly burst_len pulses, then a one-cycle done.
- Lets counter instances step at a divided rate, or advance by a fixed number of counts, without bench or CPU cycle-by-cycle control.

Parameters:
- DIV_WIDTH, 8, width of the period divider; period = div+1 clocks, range 1..2^DIV_WIDTH.
- BURST_WIDTH, 8, width of burst_len and pulse_cnt.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets immediately; release is synchronous to clk).
- start  input  1  request to begin a run; sampled only in IDLE.
- stop  input  1  abort the current run; sampled in RUN.
- mode  input  1  0 = continuous, 1 = burst; latched at start.
- div  input  DIV_WIDTH  period minus one; latched at start.
- burst_len  input  BURST_WIDTH  pulse count for burst mode; latched at start.
- enable  output  1  registered one-cycle strobe to the downstream counter.
- busy  output  1  high while a run is in progress.
- done  output  1  registered one-cycle pulse at burst completion.
- pulse_cnt  output  BURST_WIDTH  number of enables emitted in the current or last run.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; enable=0, busy=0, done=0, pulse_cnt=0.
  - Prescaler and latched div/burst_len/mode cleared to 0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start=1 and stop=0 at edge E0: latch div, burst_len, mode; prescaler<=0; pulse_cnt<=0; busy<=1; go to RUN.
  - Exception: mode=1 with burst_len=0 at E0 goes straight to DONE, emits no enable, busy stays 0.
  - start=1 and stop=1 on the same edge: stop wins; remain in IDLE with no state change.
- RUN, per edge:
  - If stop=1: go to IDLE; enable<=0; busy<=0; done stays 0; pulse_cnt holds its value. Stop overrides a coincident terminal count.
  - Else if prescaler==div_latched: enable<=1; prescaler<=0; pulse_cnt<=pulse_cnt+1.
    - In continuous mode, pulse_cnt wraps modulo 2^BURST_WIDTH.
  - Else: enable<=0; prescaler<=prescaler+1.
  - Burst mode: the edge that emits pulse number burst_len also moves state to DONE and sets busy<=0.
- DONE: done=1 for exactly one cycle; enable=0; next edge goes to IDLE with done<=0.
- Timing:
  - First enable is high in the cycle following edge E0+(div+1).
  - Subsequent enables follow every div+1 cycles.
  - div=0 gives enable high on every cycle from E0+1.
  - In burst mode, done is high in the cycle immediately after the final enable cycle. busy is low during that cycle.
- Input handling:
  - start during RUN or DONE is ignored; it is not queued.
  - Changes to div, burst_len or mode during RUN have no effect until the next start.
  - stop in IDLE or DONE is ignored.
- Reset asserted mid-run: all outputs drop to 0 asynchronously; no done is generated.
- Prescaler is DIV_WIDTH bits and never exceeds div_latched. No overflow is possible, including div = 2^DIV_WIDTH-1.

Test Plan:
- Continuous, div=3, mode=0: pulse start at t0, run 20 cycles, then stop.
  - enable high 1 cycle in every 4, first at E0+4; 5 pulses seen; pulse_cnt=5.
  - After stop: busy=0, done never asserted.
- Burst, div=0, burst_len=6, mode=1:
  - enable high 6 consecutive cycles; pulse_cnt=6.
  - done=1 for 1 cycle directly after; busy falls with the final enable edge.
  - Drive the downstream counter (WIDTH 4, MAX_VALUE 15) from enable; its count is 6.
- Burst_len=0, mode=1: start -> no enable; done=1 in the cycle after E0; busy stays 0; pulse_cnt=0.
- Collisions, div=2, burst_len=4:
  - stop asserted on a terminal-count edge after pulse 2 -> no third enable; pulse_cnt=2; done=0.
  - start+stop together in IDLE -> no run.
  - start re-pulsed mid-run -> ignored; pulse period unchanged.
  - div changed to 7 mid-run -> period stays 3.
- Asynchronous reset: assert reset=0 mid-burst, off a clock edge -> enable, busy, done, pulse_cnt = 0 immediately.
  - After release, a new start with div=1, burst_len=3 gives exactly 3 pulses at 2-cycle spacing.
- Wrap: continuous, div=0, BURST_WIDTH=8, 300 cycles -> pulse_cnt = 300 mod 256 = 44; enable never drops.

Source files
------------

// File: rtl/enable_gen_if.sv
// rtl/enable_gen_if.sv - control/status bundle between a run controller and enable_gen
// Ports (seen from the slave, i.e. enable_gen):
//    start, stop, mode, div, burst_len  -> inputs: run request, abort, mode select, period-1, burst length
//    enable, busy, done, pulse_cnt      -> outputs: strobe, run in progress, burst complete, pulses emitted
interface enable_gen_if #(
   parameter int DIV_WIDTH   = 8,
   parameter int BURST_WIDTH = 8
);
   logic                   start;
   logic                   stop;
   logic                   mode;
   logic [DIV_WIDTH-1:0]   div;
   logic [BURST_WIDTH-1:0] burst_len;
   logic                   enable;
   logic                   busy;
   logic                   done;
   logic [BURST_WIDTH-1:0] pulse_cnt;

   modport master (
      output start, stop, mode, div, burst_len,
      input  enable, busy, done, pulse_cnt
   );

   modport slave (
      input  start, stop, mode, div, burst_len,
      output enable, busy, done, pulse_cnt
   );
endinterface

// File: rtl/enable_gen.sv
// rtl/enable_gen.sv - programmable enable strobe generator, continuous or fixed-length burst
// Ports:
//    clk    rising-edge clock
//    reset  asynchronous active-low reset
//    bus    enable_gen_if.slave: start/stop/mode/div/burst_len in, enable/busy/done/pulse_cnt out
module enable_gen #(
   parameter int DIV_WIDTH   = 8,
   parameter int BURST_WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   enable_gen_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state, state_nxt;
   logic [DIV_WIDTH-1:0]   prescaler, prescaler_nxt;
   logic [DIV_WIDTH-1:0]   div_q, div_nxt;
   logic [BURST_WIDTH-1:0] len_q, len_nxt;
   logic [BURST_WIDTH-1:0] cnt_q, cnt_nxt;
   logic [BURST_WIDTH-1:0] cnt_inc;
   logic                   mode_q, mode_nxt;
   logic                   enable_q, enable_nxt;
   logic                   busy_q, busy_nxt;
   logic                   done_q, done_nxt;

   // Wraps naturally in continuous mode.
   assign cnt_inc = cnt_q + BURST_WIDTH'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         prescaler <= '0;
         div_q     <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         mode_q    <= 1'b0;
         enable_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         prescaler <= prescaler_nxt;
         div_q     <= div_nxt;
         len_q     <= len_nxt;
         cnt_q     <= cnt_nxt;
         mode_q    <= mode_nxt;
         enable_q  <= enable_nxt;
         busy_q    <= busy_nxt;
         done_q    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      prescaler_nxt = prescaler;
      div_nxt       = div_q;
      len_nxt       = len_q;
      cnt_nxt       = cnt_q;
      mode_nxt      = mode_q;
      busy_nxt      = busy_q;
      enable_nxt    = 1'b0;
      done_nxt      = 1'b0;

      case (state)
         IDLE: begin
            // stop beats a coincident start
            if (bus.start && !bus.stop) begin
               div_nxt       = bus.div;
               len_nxt       = bus.burst_len;
               mode_nxt      = bus.mode;
               prescaler_nxt = '0;
               cnt_nxt       = '0;
               if (bus.mode && (bus.burst_len == '0)) begin
                  // Empty burst: report completion immediately, never look busy.
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = RUN;
                  busy_nxt  = 1'b1;
               end
            end
         end

         RUN: begin
            if (bus.stop) begin
               // Abort wins over a terminal count on the same edge; count is kept.
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end else if (prescaler == div_q) begin
               enable_nxt    = 1'b1;
               prescaler_nxt = '0;
               cnt_nxt       = cnt_inc;
               if (mode_q && (cnt_inc == len_q)) begin
                  state_nxt = DONE;
                  busy_nxt  = 1'b0;
               end
            end else begin
               prescaler_nxt = prescaler + DIV_WIDTH'(1);
            end
         end

         DONE: begin
            // Entered either with done already set (empty burst) or straight
            // after the final enable; in the latter case raise done for one cycle.
            if (!done_q) begin
               done_nxt = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   assign bus.enable    = enable_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pulse_cnt = cnt_q;

endmodule

// File: tb/tb_enable_gen.sv
// tb/tb_enable_gen.sv - directed self-checking bench for enable_gen
module tb_enable_gen;

   logic clk;
   logic reset;
   int   vectors;
   int   errors;
   logic [3:0] ds_count;
   logic       done_seen;

   enable_gen_if #(.DIV_WIDTH(8), .BURST_WIDTH(8)) bus ();

   enable_gen #(.DIV_WIDTH(8), .BURST_WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One rising edge, then land on the falling edge to sample and drive.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      vectors       = 0;
      errors        = 0;
      reset         = 1'b0;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.mode      = 1'b0;
      bus.div       = '0;
      bus.burst_len = '0;

      // Reset state
      step();
      check("rst_enable", bus.enable, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_cnt", bus.pulse_cnt, 0);
      reset = 1'b1;
      step();

      // Continuous, div=3
      bus.mode = 1'b0; bus.div = 8'd3; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("cont_busy_e0", bus.busy, 1);
      check("cont_en_e0", bus.enable, 0);
      done_seen = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         check($sformatf("cont_en_k%0d", k), bus.enable, (k % 4 == 0) ? 1 : 0);
         if (bus.done) done_seen = 1'b1;
      end
      check("cont_cnt", bus.pulse_cnt, 5);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      check("cont_stop_busy", bus.busy, 0);
      check("cont_stop_en", bus.enable, 0);
      check("cont_stop_cnt", bus.pulse_cnt, 5);
      step();
      if (bus.done) done_seen = 1'b1;
      check("cont_no_done", done_seen, 0);

      // Burst, div=0, len=6, with a 4-bit downstream counter model
      ds_count = 4'd0;
      bus.mode = 1'b1; bus.div = 8'd0; bus.burst_len = 8'd6; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("burst_busy_e0", bus.busy, 1);
      for (int k = 1; k <= 6; k++) begin
         step();
         if (bus.enable) ds_count = ds_count + 4'd1;
         check($sformatf("burst_en_k%0d", k), bus.enable, 1);
         check($sformatf("burst_busy_k%0d", k), bus.busy, (k < 6) ? 1 : 0);
         check($sformatf("burst_done_k%0d", k), bus.done, 0);
      end
      step();
      if (bus.enable) ds_count = ds_count + 4'd1;
      check("burst_done", bus.done, 1);
      check("burst_done_en", bus.enable, 0);
      check("burst_done_busy", bus.busy, 0);
      check("burst_cnt", bus.pulse_cnt, 6);
      step();
      if (bus.enable) ds_count = ds_count + 4'd1;
      check("burst_done_drop", bus.done, 0);
      check("burst_ds_count", ds_count, 6);

      // Burst with burst_len=0
      bus.mode = 1'b1; bus.div = 8'd2; bus.burst_len = 8'd0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("zero_done", bus.done, 1);
      check("zero_en", bus.enable, 0);
      check("zero_busy", bus.busy, 0);
      check("zero_cnt", bus.pulse_cnt, 0);
      step();
      check("zero_done_drop", bus.done, 0);
      check("zero_busy2", bus.busy, 0);
      check("zero_en2", bus.enable, 0);

      // Collisions: div=2, len=4; restart + div change mid-run, stop on terminal edge
      bus.mode = 1'b1; bus.div = 8'd2; bus.burst_len = 8'd4; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 4) begin
            bus.start = 1'b1;
            bus.div   = 8'd7;
         end
         step();
         bus.start = 1'b0;
         check($sformatf("coll_en_k%0d", k), bus.enable, (k % 3 == 0) ? 1 : 0);
      end
      check("coll_cnt_pre", bus.pulse_cnt, 2);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      check("coll_stop_en", bus.enable, 0);
      check("coll_stop_busy", bus.busy, 0);
      check("coll_stop_done", bus.done, 0);
      check("coll_stop_cnt", bus.pulse_cnt, 2);
      step();
      check("coll_after_done", bus.done, 0);
      check("coll_after_en", bus.enable, 0);
      bus.start = 1'b1; bus.stop = 1'b1;
      step();
      bus.start = 1'b0; bus.stop = 1'b0;
      check("ss_busy", bus.busy, 0);
      check("ss_cnt", bus.pulse_cnt, 2);
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("ss_en_k%0d", k), bus.enable, 0);
      end
      check("ss_busy2", bus.busy, 0);

      // Asynchronous reset mid-burst
      bus.mode = 1'b1; bus.div = 8'd2; bus.burst_len = 8'd4; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 1; k <= 3; k++) step();
      check("ar_pre_en", bus.enable, 1);
      check("ar_pre_cnt", bus.pulse_cnt, 1);
      #2 reset = 1'b0;
      #1;
      check("ar_en", bus.enable, 0);
      check("ar_busy", bus.busy, 0);
      check("ar_done", bus.done, 0);
      check("ar_cnt", bus.pulse_cnt, 0);
      @(negedge clk);
      reset = 1'b1;
      step();
      check("ar_idle_done", bus.done, 0);
      bus.div = 8'd1; bus.burst_len = 8'd3; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step();
         check($sformatf("ar_en_k%0d", k), bus.enable, (k % 2 == 0) ? 1 : 0);
      end
      check("ar_cnt_final", bus.pulse_cnt, 3);
      check("ar_busy_final", bus.busy, 0);
      step();
      check("ar_done_final", bus.done, 1);
      check("ar_en_after", bus.enable, 0);
      step();

      // Continuous wrap, div=0, 300 cycles
      bus.mode = 1'b0; bus.div = 8'd0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         step();
         if (bus.enable !== 1'b1 || k == 1 || k == 300)
            check($sformatf("wrap_en_k%0d", k), bus.enable, 1);
      end
      check("wrap_cnt", bus.pulse_cnt, 44);
      check("wrap_busy", bus.busy, 1);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      check("wrap_stop_busy", bus.busy, 0);
      check("wrap_stop_cnt", bus.pulse_cnt, 44);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
